// File: rtl/path_aggregate_lr_if.sv
// Pixel-stream bundle between the penalty-add stage, the left-to-right
// aggregator and the multi-path cost summer. Costs are packed 8 bits per disparity.
interface path_aggregate_lr_if #(
    parameter int D = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [8*D-1:0] in_cost;
    logic           in_sol;
    logic           out_valid;
    logic           out_ready;
    logic [8*D-1:0] out_lr;
    logic [7:0]     out_min;

    modport master (
        output in_valid, in_cost, in_sol, out_ready,
        input  in_ready, out_valid, out_lr, out_min
    );

    modport slave (
        input  in_valid, in_cost, in_sol, out_ready,
        output in_ready, out_valid, out_lr, out_min
    );
endinterface

// File: rtl/path_aggregate_lr.sv
// Left-to-right SGBM path-cost aggregation: one D-entry cost vector per pixel,
// three-state IDLE/AGG/EMIT sequencer, history updated only on output handshake.
module path_aggregate_lr #(
    parameter int D  = 16,
    parameter int P1 = 10,
    parameter int P2 = 120
) (
    input  logic                clk,
    input  logic                rst_n,
    path_aggregate_lr_if.slave  bus,
    output logic [1:0]          dbg_state
);
    // Handshakes: a beat transfers on a rising edge where valid && ready are
    // both high; valid never depends on ready, and payload is held while valid
    // is high and ready is low.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AGG  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [9:0] P1_W    = 10'(P1);
    localparam logic [9:0] P2_W    = 10'(P2);
    localparam logic [9:0] NO_CAND = 10'h3FF;

    if (D < 2) begin : g_bad_d
        $error("path_aggregate_lr: D must be at least 2");
    end
    if (P2 < P1) begin : g_bad_p
        $error("path_aggregate_lr: P2 must be >= P1");
    end

    state_t              state_q, state_d;
    logic [D-1:0][7:0]   c_q, c_d;
    logic                sol_q, sol_d;
    logic [D-1:0][7:0]   lr_q, lr_d;
    logic [7:0]          min_q, min_d;
    logic [D-1:0][7:0]   prev_lr_q, prev_lr_d;
    logic [7:0]          prev_min_q, prev_min_d;
    logic                have_prev_q, have_prev_d;

    logic [D-1:0][7:0]   lr_agg;
    logic [7:0]          min_agg;
    logic                start_agg;
    logic                in_ready;

    // Ready is forced low while reset is held, even though the state is IDLE.
    assign in_ready      = rst_n && (state_q == IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_lr    = lr_q;
    assign bus.out_min   = min_q;
    assign dbg_state     = state_q;

    assign start_agg = sol_q || !have_prev_q;

    for (genvar g = 0; g < D; g++) begin : g_lane
        logic [9:0] a, b, c, e;
        logic [9:0] m_ab, m_ce, m, diff, sum;

        assign a = {2'b00, prev_lr_q[g]};
        // Missing neighbours become an unbeatable candidate, never zero.
        if (g > 0) begin : g_lo
            assign b = {2'b00, prev_lr_q[g-1]} + P1_W;
        end else begin : g_lo_edge
            assign b = NO_CAND;
        end
        if (g < D - 1) begin : g_hi
            assign c = {2'b00, prev_lr_q[g+1]} + P1_W;
        end else begin : g_hi_edge
            assign c = NO_CAND;
        end
        assign e    = {2'b00, prev_min_q} + P2_W;
        assign m_ab = (a < b) ? a : b;
        assign m_ce = (c < e) ? c : e;
        assign m    = (m_ab < m_ce) ? m_ab : m_ce;
        assign diff = m - {2'b00, prev_min_q};
        assign sum  = {2'b00, c_q[g]} + diff;

        assign lr_agg[g] = start_agg ? c_q[g]
                         : ((sum > 10'd255) ? 8'hFF : sum[7:0]);
    end

    always_comb begin
        min_agg = lr_agg[0];
        for (int i = 1; i < D; i++) begin
            if (lr_agg[i] < min_agg) begin
                min_agg = lr_agg[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        sol_d       = sol_q;
        lr_d        = lr_q;
        min_d       = min_q;
        prev_lr_d   = prev_lr_q;
        prev_min_d  = prev_min_q;
        have_prev_d = have_prev_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    c_d     = bus.in_cost;
                    sol_d   = bus.in_sol;
                    state_d = AGG;
                end
            end
            AGG: begin
                lr_d    = lr_agg;
                min_d   = min_agg;
                state_d = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    prev_lr_d   = lr_q;
                    prev_min_d  = min_q;
                    have_prev_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_q         <= '0;
            sol_q       <= 1'b0;
            lr_q        <= '0;
            min_q       <= '0;
            prev_lr_q   <= '0;
            prev_min_q  <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            sol_q       <= sol_d;
            lr_q        <= lr_d;
            min_q       <= min_d;
            prev_lr_q   <= prev_lr_d;
            prev_min_q  <= prev_min_d;
            have_prev_q <= have_prev_d;
        end
    end
endmodule

// File: tb/tb_path_aggregate_lr.sv
// Bench for path_aggregate_lr: directed vectors from the test plan plus
// randomized pixels checked against a plain-arithmetic path-cost model.
module tb_path_aggregate_lr;
    localparam int D  = 4;
    localparam int P1 = 10;
    localparam int P2 = 120;
    localparam int W  = 8 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    path_aggregate_lr_if #(.D(D)) bus ();

    path_aggregate_lr #(.D(D), .P1(P1), .P2(P2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: previous pixel's Lr vector and its minimum.
    int m_prev[D];
    int m_prev_min;
    bit m_have;
    logic [W+7:0] exp_q[$];

    function automatic void model_reset();
        for (int d = 0; d < D; d++) m_prev[d] = 0;
        m_prev_min = 0;
        m_have     = 1'b0;
    endfunction

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    // Returns {min, lr_vector} and advances the model history.
    function automatic logic [W+7:0] model_step(input bit sol, input logic [W-1:0] cost);
        int lr[D];
        int mn = 255;
        logic [W+7:0] r;
        for (int d = 0; d < D; d++) begin
            int cv;
            cv = int'(cost[8*d +: 8]);
            if (sol || !m_have) begin
                lr[d] = cv;
            end else begin
                int best;
                best = m_prev[d];
                if (d > 0)     best = imin(best, m_prev[d-1] + P1);
                if (d < D - 1) best = imin(best, m_prev[d+1] + P1);
                best = imin(best, m_prev_min + P2);
                lr[d] = imin(255, cv + best - m_prev_min);
            end
            mn = imin(mn, lr[d]);
            r[8*d +: 8] = 8'(lr[d]);
        end
        r[W +: 8] = 8'(mn);
        for (int d = 0; d < D; d++) m_prev[d] = lr[d];
        m_prev_min = mn;
        m_have     = 1'b1;
        return r;
    endfunction

    // Drives one pixel through the full accept -> AGG -> EMIT -> handshake
    // sequence; called at posedge+1 with the DUT in IDLE.
    task automatic run_pixel(input bit sol, input logic [W-1:0] cost, input int hold,
                             output logic [W-1:0] lr, output logic [7:0] mn,
                             output int lat, output bit stable, output bit blocked,
                             output bit gone);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b1;
        bus.in_sol   = sol;
        bus.in_cost  = cost;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sol   = ~sol;
        bus.in_cost  = {$urandom(), $urandom()};
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        lr      = bus.out_lr;
        mn      = bus.out_min;
        stable  = 1'b1;
        blocked = 1'b1;
        repeat (hold) begin
            bus.in_valid = 1'b1;
            bus.in_cost  = {$urandom(), $urandom()};
            @(posedge clk); #1;
            if (bus.out_lr !== lr || bus.out_min !== mn || bus.out_valid !== 1'b1) stable = 1'b0;
            if (bus.in_ready !== 1'b0) blocked = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        gone = (bus.out_valid === 1'b0);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_sol    = 1'b0;
        bus.in_cost   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready_low got=%b exp=0", bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        total++;
        if (bus.out_lr !== '0) begin
            bad++; $display("FAIL reset_out_lr got=%h exp=0", bus.out_lr);
        end
        total++;
        if (bus.out_min !== 8'd0) begin
            bad++; $display("FAIL reset_out_min got=%h exp=0", bus.out_min);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready_idle got=%b exp=1", bus.in_ready);
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
    endtask

    task automatic test_start_of_line();
        logic [W-1:0] lr; logic [7:0] mn; int lat; bit st, bl, gn;
        logic [W+7:0] ex;
        ex = model_step(1'b1, 32'hFF1E1405);
        run_pixel(1'b1, 32'hFF1E1405, 0, lr, mn, lat, st, bl, gn);
        total++;
        if (lr !== 32'hFF1E1405) begin
            bad++; $display("FAIL sol_lr got=%h exp=ff1e1405", lr);
        end
        total++;
        if (mn !== 8'd5) begin
            bad++; $display("FAIL sol_min got=%0d exp=5", mn);
        end
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL sol_latency got=%0d exp=2", lat);
        end
        total++;
        if ({mn, lr} !== ex) begin
            bad++; $display("FAIL sol_model got=%h exp=%h", {mn, lr}, ex);
        end
    endtask

    task automatic test_penalty();
        logic [W-1:0] lr; logic [7:0] mn; int lat; bit st, bl, gn;
        logic [W+7:0] ex;
        ex = model_step(1'b0, 32'h0);
        run_pixel(1'b0, 32'h0, 0, lr, mn, lat, st, bl, gn);
        total++;
        if (lr !== 32'h23190A00 || mn !== 8'd0) begin
            bad++; $display("FAIL penalty_lr got=%h/%0d exp=23190a00/0", lr, mn);
        end
        total++;
        if ({mn, lr} !== ex) begin
            bad++; $display("FAIL penalty_model got=%h exp=%h", {mn, lr}, ex);
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] lr; logic [7:0] mn; int lat; bit st, bl, gn;
        logic [W+7:0] ex;
        ex = model_step(1'b0, 32'hFAFAFAFA);
        run_pixel(1'b0, 32'hFAFAFAFA, 0, lr, mn, lat, st, bl, gn);
        total++;
        if (lr !== 32'hFFFFFFFA || mn !== 8'd250) begin
            bad++; $display("FAIL saturation_lr got=%h/%0d exp=fffffffa/250", lr, mn);
        end
        total++;
        if ({mn, lr} !== ex) begin
            bad++; $display("FAIL saturation_model got=%h exp=%h", {mn, lr}, ex);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] lr; logic [7:0] mn; int lat; bit st, bl, gn;
        logic [W-1:0] cost;
        logic [W+7:0] ex;
        cost = $urandom();
        ex = model_step(1'b0, cost);
        run_pixel(1'b0, cost, 5, lr, mn, lat, st, bl, gn);
        total++;
        if (!st) begin
            bad++; $display("FAIL bp_stable got=0 exp=1");
        end
        total++;
        if (!bl) begin
            bad++; $display("FAIL bp_in_ready_low got=0 exp=1");
        end
        total++;
        if ({mn, lr} !== ex) begin
            bad++; $display("FAIL bp_model got=%h exp=%h", {mn, lr}, ex);
        end
        total++;
        if (!gn || dbg_state !== 2'd0) begin
            bad++; $display("FAIL bp_release got=%b/%0d exp=1/0", gn, dbg_state);
        end
        ex = model_step(1'b1, 32'h07070707);
        run_pixel(1'b1, 32'h07070707, 0, lr, mn, lat, st, bl, gn);
        total++;
        if (lr !== 32'h07070707 || mn !== 8'd7) begin
            bad++; $display("FAIL bp_sol_lr got=%h/%0d exp=07070707/7", lr, mn);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] lr; logic [7:0] mn; int lat; bit st, bl, gn;
        int rises = 0;
        logic [W+7:0] ex;
        bus.in_valid = 1'b1;
        bus.in_sol   = 1'b0;
        bus.in_cost  = 32'h11223344;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if (dbg_state !== 2'd1) begin
            bad++; $display("FAIL rstmid_in_agg got=%0d exp=1", dbg_state);
        end
        rst_n = 1'b0;
        #2;
        total++;
        if (dbg_state !== 2'd0 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_async got=%0d/%b exp=0/0", dbg_state, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) rises++;
        end
        total++;
        if (rises !== 0) begin
            bad++; $display("FAIL rstmid_no_output got=%0d exp=0", rises);
        end
        model_reset();
        ex = model_step(1'b0, 32'h01040103);
        run_pixel(1'b0, 32'h01040103, 0, lr, mn, lat, st, bl, gn);
        total++;
        if (lr !== 32'h01040103 || mn !== 8'd1) begin
            bad++; $display("FAIL rstmid_next_lr got=%h/%0d exp=01040103/1", lr, mn);
        end
        total++;
        if ({mn, lr} !== ex) begin
            bad++; $display("FAIL rstmid_model got=%h exp=%h", {mn, lr}, ex);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] lr; logic [7:0] mn; int lat; bit st, bl, gn;
        time t0, t1;
        logic [W+7:0] ex;
        logic [W-1:0] cost;
        t0 = $time;
        for (int i = 0; i < 4; i++) begin
            cost = $urandom();
            ex = model_step(1'b0, cost);
            run_pixel(1'b0, cost, 0, lr, mn, lat, st, bl, gn);
            total++;
            if ({mn, lr} !== ex) begin
                bad++; $display("FAIL b2b_model got=%h exp=%h", {mn, lr}, ex);
            end
        end
        t1 = $time;
        total++;
        if ((t1 - t0) !== 120) begin
            bad++; $display("FAIL b2b_spacing got=%0t exp=120", t1 - t0);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] lr; logic [7:0] mn; int lat; bit st, bl, gn;
        logic [W-1:0] cost;
        logic [W+7:0] ex;
        bit sol;
        for (int i = 0; i < 40; i++) begin
            sol = ($urandom_range(0, 7) == 0);
            for (int d = 0; d < D; d++) begin
                case ($urandom_range(0, 3))
                    0: cost[8*d +: 8] = 8'(($urandom_range(0, 15)));
                    1: cost[8*d +: 8] = 8'(($urandom_range(240, 255)));
                    default: cost[8*d +: 8] = 8'($urandom_range(0, 255));
                endcase
            end
            exp_q.push_back(model_step(sol, cost));
            run_pixel(sol, cost, $urandom_range(0, 3), lr, mn, lat, st, bl, gn);
            ex = exp_q.pop_front();
            total++;
            if ({mn, lr} !== ex) begin
                bad++; $display("FAIL rand_lr[%0d] got=%h exp=%h", i, {mn, lr}, ex);
            end
            total++;
            if (lat !== 2 || !st || !bl || !gn) begin
                bad++; $display("FAIL rand_timing[%0d] got=lat%0d/%b%b%b exp=lat2/111", i, lat, st, bl, gn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_of_line();
        test_penalty();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
